// File: rtl/core_regfile_pkg.sv
// rtl/core_regfile_pkg.sv - shared types and the byte-lane merge helper for the core register file
package core_regfile_pkg;

  // Widest XLEN the lane_merge helper handles; callers cast in and out.
  localparam int MAX_XLEN = 128;
  localparam int MAX_LW   = 4;

  typedef enum logic {
    BANK_INT = 1'b0,
    BANK_FP  = 1'b1
  } bank_e;

  typedef enum logic {
    WK_WORD = 1'b0,
    WK_BYTE = 1'b1
  } wkind_e;

  // Control half of the write stage; address, data and lane sit beside it
  // because their widths follow the top-level parameters.
  typedef struct packed {
    logic   valid;
    wkind_e kind;
    bank_e  bank;
  } wr_ctrl_t;

  function automatic logic [MAX_XLEN-1:0] lane_merge(
    input logic [MAX_XLEN-1:0] word,
    input logic [7:0]          byte_in,
    input logic [MAX_LW-1:0]   lane
  );
    logic [MAX_XLEN-1:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = byte_in;
    return r;
  endfunction

endpackage

// File: rtl/core_regfile_p_bank.sv
// rtl/core_regfile_p_bank.sv - one NREG x XLEN bank, commit port, two registered reads (optional CORE_REGFILE_BYPASS_EN)
module core_regbank
  import core_regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int LW   = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  wkind_e          wr_kind,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [LW-1:0]   wr_lane,
  input  logic [AW-1:0]   rd1_addr,
  input  logic [AW-1:0]   rd2_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data
);

  localparam logic [AW:0] NREG_LIM = (AW + 1)'(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [XLEN-1:0] commit_val;
  logic            wr_ok;

  // Register 0 and anything past the last register are never storage.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_LIM);
  endfunction

  // Value landing at commit; byte writes merge against the current array contents.
  always_comb begin
    wr_ok      = wr_en && addr_live(wr_addr);
    commit_val = wr_data;
    if (wr_kind == WK_BYTE && addr_live(wr_addr)) begin
      commit_val = XLEN'(lane_merge(MAX_XLEN'(mem_q[wr_addr]), wr_data[7:0], MAX_LW'(wr_lane)));
    end
  end

  // Next array state: copy through, then apply the commit.
  always_comb begin
    for (int i = 0; i < NREG; i++) mem_d[i] = mem_q[i];
    if (wr_ok) mem_d[wr_addr] = commit_val;
  end

  // Read port next values, with the zero rules and the optional commit bypass.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (addr_live(rd1_addr)) begin
      rd1_d = mem_q[rd1_addr];
`ifdef CORE_REGFILE_BYPASS_EN
      if (wr_ok && wr_addr == rd1_addr) rd1_d = commit_val;
`endif
    end
    if (addr_live(rd2_addr)) begin
      rd2_d = mem_q[rd2_addr];
`ifdef CORE_REGFILE_BYPASS_EN
      if (wr_ok && wr_addr == rd2_addr) rd2_d = commit_val;
`endif
    end
  end

  // Storage and read registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign rd1_data = rd1_q;
  assign rd2_data = rd2_q;

endmodule

// File: rtl/core_regfile_p.sv
// rtl/core_regfile_p.sv - integer/float register file top with write stage and PC (optional CORE_REGFILE_BYPASS_EN)
module core_regfile_p #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              AW       = $clog2(NREG),
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      WE,
  input  logic                      WBANK,
  input  logic [AW-1:0]             WADDR,
  input  logic [XLEN-1:0]           WDATA,
  input  logic                      INE,
  input  logic [$clog2(XLEN/8)-1:0] INLANE,
  input  logic [7:0]                INDATA,
  input  logic [AW-1:0]             RS1ADDR,
  input  logic [AW-1:0]             RS2ADDR,
  output logic [XLEN-1:0]           RS1,
  output logic [XLEN-1:0]           RS2,
  input  logic [AW-1:0]             FRS1ADDR,
  input  logic [AW-1:0]             FRS2ADDR,
  output logic [XLEN-1:0]           FRS1,
  output logic [XLEN-1:0]           FRS2,
  input  logic                      PC_WE,
  input  logic [XLEN-1:0]           PC_WDATA,
  output logic [XLEN-1:0]           PC
);
  import core_regfile_pkg::*;

  localparam int LW = $clog2(XLEN / 8);

  wr_ctrl_t        ctrl_q, ctrl_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [LW-1:0]   wlane_q, wlane_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            int_we, fp_we;

  // Write stage load: a word request wins over a byte request; byte writes always target the integer bank.
  always_comb begin
    ctrl_d.valid = WE | INE;
    ctrl_d.kind  = WE ? WK_WORD : WK_BYTE;
    ctrl_d.bank  = WE ? bank_e'(WBANK) : BANK_INT;
    waddr_d      = WADDR;
    wdata_d      = WE ? WDATA : XLEN'(INDATA);
    wlane_d      = INLANE;
    pc_d         = PC_WE ? PC_WDATA : pc_q;
  end

  // Write stage and PC registers; reset drops any in-flight write.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ctrl_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wlane_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      ctrl_q  <= ctrl_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wlane_q <= wlane_d;
      pc_q    <= pc_d;
    end
  end

  assign int_we = ctrl_q.valid && (ctrl_q.bank == BANK_INT);
  assign fp_we  = ctrl_q.valid && (ctrl_q.bank == BANK_FP);
  assign PC     = pc_q;

  core_regbank #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .LW(LW)) u_int_bank (
    .clk      (CLK),
    .rst_n    (RST_N),
    .wr_en    (int_we),
    .wr_kind  (ctrl_q.kind),
    .wr_addr  (waddr_q),
    .wr_data  (wdata_q),
    .wr_lane  (wlane_q),
    .rd1_addr (RS1ADDR),
    .rd2_addr (RS2ADDR),
    .rd1_data (RS1),
    .rd2_data (RS2)
  );

  core_regbank #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .LW(LW)) u_fp_bank (
    .clk      (CLK),
    .rst_n    (RST_N),
    .wr_en    (fp_we),
    .wr_kind  (ctrl_q.kind),
    .wr_addr  (waddr_q),
    .wr_data  (wdata_q),
    .wr_lane  (wlane_q),
    .rd1_addr (FRS1ADDR),
    .rd2_addr (FRS2ADDR),
    .rd1_data (FRS1),
    .rd2_data (FRS2)
  );

endmodule
